// File: rtl/mic_capture_sequencer.sv
// mic_capture_sequencer: sample-tick ADC handshake sequencer with windowed peak and 0-9 volume level.
// Define PEAK_HOLD_EN to make the volume decay by one step per window instead of following each peak.
module mic_capture_sequencer #(
    parameter int CLK_DIV  = 5000,
    parameter int WINDOW   = 128,
    parameter int MIDPOINT = 2048
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    output logic        adc_start,
    input  logic        adc_busy,
    input  logic        adc_done,
    input  logic [11:0] adc_sample,
    output logic [11:0] peak,
    output logic        peak_valid,
    output logic [3:0]  volume,
    output logic        overrun,
    input  logic        clear_overrun
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   best_q, best_d, peak_q, peak_d, hi;
    logic [15:0]   scnt_q, scnt_d;
    logic [3:0]    vol_q, vol_d, lvl, vol_new;
    logic          pv_q, pv_d, ovr_q, ovr_d, tick, capture, last;

    function automatic logic [3:0] level(input logic [11:0] p);
        return p < 12'd2064 ? 4'd0 : p < 12'd2090 ? 4'd1 : p < 12'd2100 ? 4'd2 :
               p < 12'd2112 ? 4'd3 : p < 12'd2150 ? 4'd4 : p < 12'd2176 ? 4'd5 :
               p < 12'd2224 ? 4'd6 : p < 12'd2304 ? 4'd7 : p < 12'd2560 ? 4'd8 : 4'd9;
    endfunction

    assign tick  = enable && (cnt_q == CW'(CLK_DIV - 1));
    assign cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;
    assign hi    = (adc_sample > best_q) ? adc_sample : best_q;
    assign last  = scnt_q == 16'(WINDOW - 1);
    assign lvl   = level(hi);

`ifdef PEAK_HOLD_EN
    assign vol_new = (lvl >= vol_q) ? lvl : (vol_q == 4'd0 ? 4'd0 : vol_q - 4'd1);
`else
    assign vol_new = lvl;
`endif

    // A tick that finds a conversion still outstanding is dropped and flagged.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        ovr_d   = ovr_q && !clear_overrun;
        case (state_q)
            IDLE: if (tick) state_d = START;
            START: begin
                if (adc_busy) state_d = WAIT;
                if (tick) ovr_d = 1'b1;
            end
            WAIT: begin
                if (adc_done) begin
                    capture = 1'b1;
                    state_d = tick ? START : IDLE;
                end else if (tick) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        best_d = best_q;
        scnt_d = scnt_q;
        peak_d = peak_q;
        vol_d  = vol_q;
        pv_d   = 1'b0;
        if (capture) begin
            best_d = last ? 12'(MIDPOINT) : hi;
            scnt_d = last ? 16'd0 : scnt_q + 16'd1;
            peak_d = last ? hi : peak_q;
            vol_d  = last ? vol_new : vol_q;
            pv_d   = last;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            best_q  <= 12'(MIDPOINT);
            peak_q  <= 12'(MIDPOINT);
            scnt_q  <= '0;
            vol_q   <= '0;
            pv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            peak_q  <= peak_d;
            scnt_q  <= scnt_d;
            vol_q   <= vol_d;
            pv_q    <= pv_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc_start  = state_q == START;
    assign peak       = peak_q;
    assign peak_valid = pv_q;
    assign volume     = vol_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_mic_capture_sequencer.sv
// tb_mic_capture_sequencer: randomized bench for mic_capture_sequencer with a responding ADC model.
// The scoreboard keeps each window as a list of samples, reduces it by max and maps it through the level table.
module tb_mic_capture_sequencer;
    localparam int CLK_DIV = 8, WINDOW = 4, MIDPOINT = 2048;

    logic        clock = 1'b0, reset_n = 1'b0, enable = 1'b0, clear_overrun = 1'b0;
    logic        adc_busy = 1'b0, adc_done = 1'b0, adc_start, peak_valid, overrun;
    logic [11:0] adc_sample = '0, peak;
    logic [3:0]  volume;

    int checks = 0, passes = 0, pubs = 0, busy_left = 0, fixed_busy = 0;
    bit never_done = 1'b0;
    logic [11:0] sample_q[$];
    logic [11:0] win[$];
    logic [11:0] exp_peak = 12'(MIDPOINT), m_max;
    logic [3:0]  exp_vol = '0, m_lvl;
    logic        exp_pv = 1'b0;
    int thr[9] = '{2064, 2090, 2100, 2112, 2150, 2176, 2224, 2304, 2560};

    mic_capture_sequencer #(.CLK_DIV(CLK_DIV), .WINDOW(WINDOW), .MIDPOINT(MIDPOINT)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .adc_start(adc_start),
        .adc_busy(adc_busy), .adc_done(adc_done), .adc_sample(adc_sample), .peak(peak),
        .peak_valid(peak_valid), .volume(volume), .overrun(overrun), .clear_overrun(clear_overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] lvl_of(input logic [11:0] p);
        int n = 0;
        foreach (thr[i]) if (int'(p) >= thr[i]) n++;
        return 4'(n);
    endfunction

    // ADC front end: acknowledges a start, stays busy a few cycles, then pulses done with a sample.
    initial forever begin
        @(negedge clock);
        adc_done = 1'b0;
        if (!reset_n) begin
            busy_left = 0;
            adc_busy  = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0 && !never_done) begin
                adc_busy = 1'b0;
                adc_done = 1'b1;
                if (sample_q.size() > 0) adc_sample = sample_q.pop_front();
                else adc_sample = 12'($urandom_range(1900, 2700));
            end
        end else if (adc_start && !adc_busy) begin
            adc_busy  = 1'b1;
            busy_left = fixed_busy > 0 ? fixed_busy : int'($urandom_range(1, 3));
        end
    end

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            win.delete();
            exp_peak = 12'(MIDPOINT);
            exp_vol  = '0;
            exp_pv   = 1'b0;
        end else begin
            exp_pv = 1'b0;
            if (adc_done) begin
                win.push_back(adc_sample);
                if (win.size() == WINDOW) begin
                    m_max = 12'(MIDPOINT);
                    foreach (win[i]) if (win[i] > m_max) m_max = win[i];
                    m_lvl = lvl_of(m_max);
`ifdef PEAK_HOLD_EN
                    exp_vol = (m_lvl >= exp_vol) ? m_lvl : (exp_vol == 4'd0 ? 4'd0 : exp_vol - 4'd1);
`else
                    exp_vol = m_lvl;
`endif
                    exp_peak = m_max;
                    exp_pv   = 1'b1;
                    pubs++;
                    win.delete();
                end
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; clear_overrun = 1'b0; never_done = 1'b0; fixed_busy = 0;
        sample_q.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int starts = 0;
        reset_n = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (adc_start !== 1'b0) $display("FAIL reset_adc_start: got %0b want 0", adc_start); else passes++;
        checks++; if (peak !== 12'd2048) $display("FAIL reset_peak: got %0d want 2048", peak); else passes++;
        checks++; if (peak_valid !== 1'b0) $display("FAIL reset_peak_valid: got %0b want 0", peak_valid); else passes++;
        checks++; if (volume !== 4'd0) $display("FAIL reset_volume: got %0d want 0", volume); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b want 0", overrun); else passes++;
        reset_n = 1'b1;
        repeat (3 * CLK_DIV) begin
            @(negedge clock);
            if (adc_start) starts++;
        end
        checks++; if (starts !== 0) $display("FAIL disabled_no_start: got %0d want 0", starts); else passes++;
    endtask

    task automatic test_cadence();
        int next_rise = CLK_DIV, rises = 0;
        logic prev = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 6 * CLK_DIV + 2; i++) begin
            @(negedge clock);
            if (adc_start && !prev) begin
                checks++; if (i !== next_rise) $display("FAIL cadence_rise: got cycle %0d want %0d", i, next_rise); else passes++;
                next_rise += CLK_DIV;
                rises++;
            end
            prev = adc_start;
        end
        checks++; if (rises !== 6) $display("FAIL cadence_count: got %0d want 6", rises); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL cadence_overrun: got %0b want 0", overrun); else passes++;
    endtask

    task automatic test_window();
        logic [11:0] want_pk[2] = '{12'd3000, 12'd2048};
`ifdef PEAK_HOLD_EN
        logic [3:0] want_vol[2] = '{4'd9, 4'd8};
`else
        logic [3:0] want_vol[2] = '{4'd9, 4'd0};
`endif
        int n = 0;
        do_reset();
        sample_q = '{12'd2100, 12'd3000, 12'd2050, 12'd1000, 12'd100, 12'd200, 12'd300, 12'd400};
        enable = 1'b1;
        for (int i = 0; i < 12 * CLK_DIV && n < 2; i++) begin
            @(negedge clock);
            checks++; if (peak_valid !== exp_pv) $display("FAIL window_pv: got %0b want %0b at %0t", peak_valid, exp_pv, $time); else passes++;
            if (peak_valid) begin
                checks++; if (peak !== want_pk[n]) $display("FAIL window_peak%0d: got %0d want %0d", n, peak, want_pk[n]); else passes++;
                checks++; if (volume !== want_vol[n]) $display("FAIL window_vol%0d: got %0d want %0d", n, volume, want_vol[n]); else passes++;
                n++;
            end
        end
        checks++; if (n !== 2) $display("FAIL window_publishes: got %0d want 2", n); else passes++;
    endtask

    task automatic test_levels();
        int pk[23] = '{2600, 2000, 2000, 2120, 2063, 2064, 2089, 2090, 2099, 2100, 2111, 2112,
                       2149, 2150, 2175, 2176, 2223, 2224, 2303, 2304, 2559, 2560, 4095};
`ifdef PEAK_HOLD_EN
        logic [3:0] want_vol[4] = '{4'd9, 4'd8, 4'd7, 4'd6};
`else
        logic [3:0] want_vol[4] = '{4'd9, 4'd0, 4'd0, 4'd4};
`endif
        int n = 0, pos;
        do_reset();
        foreach (pk[j]) begin
            pos = $urandom_range(0, WINDOW - 1);
            for (int k = 0; k < WINDOW; k++)
                sample_q.push_back(k == pos ? 12'(pk[j]) : 12'($urandom_range(0, 2047)));
        end
        enable = 1'b1;
        for (int i = 0; i < 24 * WINDOW * CLK_DIV && n < 23; i++) begin
            @(negedge clock);
            checks++; if (peak_valid !== exp_pv) $display("FAIL levels_pv: got %0b want %0b at %0t", peak_valid, exp_pv, $time); else passes++;
            if (peak_valid) begin
                checks++; if (peak !== exp_peak) $display("FAIL levels_peak: got %0d want %0d", peak, exp_peak); else passes++;
                checks++; if (volume !== exp_vol) $display("FAIL levels_vol: peak %0d got %0d want %0d", peak, volume, exp_vol); else passes++;
                if (n < 4) begin
                    checks++; if (volume !== want_vol[n]) $display("FAIL levels_seq%0d: got %0d want %0d", n, volume, want_vol[n]); else passes++;
                end
                n++;
            end
        end
        checks++; if (n !== 23) $display("FAIL levels_publishes: got %0d want 23", n); else passes++;
    endtask

    task automatic test_enable_drop();
        int rises = 0, n = 0;
        logic prev = 1'b0;
        bit found = 1'b0;
        do_reset();
        fixed_busy = 3;
        enable = 1'b1;
        for (int i = 0; i < 6 * CLK_DIV && !found; i++) begin
            @(negedge clock);
            found = adc_start && win.size() == 2;
        end
        checks++; if (!found) $display("FAIL drop_reach_third: got 0 want 1"); else passes++;
        @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 5 * CLK_DIV; i++) begin
            @(negedge clock);
            if (adc_start && !prev) rises++;
            prev = adc_start;
            checks++; if (peak_valid !== exp_pv) $display("FAIL drop_pv: got %0b want %0b", peak_valid, exp_pv); else passes++;
        end
        checks++; if (rises !== 0) $display("FAIL drop_no_start: got %0d want 0", rises); else passes++;
        enable = 1'b1;
        for (int i = 0; i < 3 * CLK_DIV && n == 0; i++) begin
            @(negedge clock);
            if (adc_start && !prev) rises++;
            prev = adc_start;
            checks++; if (peak_valid !== exp_pv) $display("FAIL resume_pv: got %0b want %0b", peak_valid, exp_pv); else passes++;
            if (peak_valid) begin
                n++;
                checks++; if (peak !== exp_peak) $display("FAIL resume_peak: got %0d want %0d", peak, exp_peak); else passes++;
            end
        end
        checks++; if (n !== 1) $display("FAIL resume_publish: got %0d want 1", n); else passes++;
        checks++; if (rises !== 1) $display("FAIL resume_starts: got %0d want 1", rises); else passes++;
        fixed_busy = 0;
    endtask

    task automatic test_overrun();
        int rises = 0;
        logic prev = 1'b0;
        do_reset();
        never_done = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (adc_start && !prev) rises++;
            prev = adc_start;
            if (i == 15) begin
                checks++; if (overrun !== 1'b0) $display("FAIL ovr_before_tick: got %0b want 0", overrun); else passes++;
            end
            if (i == 16) begin
                checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %0b want 1", overrun); else passes++;
            end
            if (i == 20) clear_overrun = 1'b1;
            if (i == 21) begin
                clear_overrun = 1'b0;
                checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %0b want 0", overrun); else passes++;
            end
            if (i == 23) clear_overrun = 1'b1;
            if (i == 24) begin
                clear_overrun = 1'b0;
                checks++; if (overrun !== 1'b1) $display("FAIL ovr_clear_vs_tick: got %0b want 1", overrun); else passes++;
            end
        end
        checks++; if (rises !== 1) $display("FAIL ovr_single_start: got %0d want 1", rises); else passes++;
        never_done = 1'b0;
    endtask

    task automatic test_random_windows();
        int n = 0;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4000 && n < 12; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 19) == 0) enable = !enable;
            if ($urandom_range(0, 3) == 0) sample_q.push_back(12'($urandom_range(0, 4095)));
            checks++; if (peak_valid !== exp_pv) $display("FAIL rand_pv: got %0b want %0b at %0t", peak_valid, exp_pv, $time); else passes++;
            if (peak_valid) begin
                n++;
                checks++; if (peak !== exp_peak) $display("FAIL rand_peak: got %0d want %0d", peak, exp_peak); else passes++;
                checks++; if (volume !== exp_vol) $display("FAIL rand_vol: got %0d want %0d", volume, exp_vol); else passes++;
            end
        end
        checks++; if (n !== 12) $display("FAIL rand_publishes: got %0d want 12", n); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL rand_overrun: got %0b want 0", overrun); else passes++;
        enable = 1'b1;
    endtask

    task automatic test_reset_async();
        bit found = 1'b0;
        int rise_at = -1;
        for (int i = 0; i < 4 * CLK_DIV && !found; i++) begin
            @(negedge clock);
            found = adc_start;
        end
        checks++; if (!found) $display("FAIL async_reach_start: got 0 want 1"); else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (adc_start !== 1'b0) $display("FAIL async_adc_start: got %0b want 0", adc_start); else passes++;
        checks++; if (peak !== 12'd2048) $display("FAIL async_peak: got %0d want 2048", peak); else passes++;
        checks++; if (volume !== 4'd0) $display("FAIL async_volume: got %0d want 0", volume); else passes++;
        checks++; if (peak_valid !== 1'b0) $display("FAIL async_pv: got %0b want 0", peak_valid); else passes++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 1; i <= 3 * CLK_DIV && rise_at < 0; i++) begin
            @(negedge clock);
            if (adc_start) rise_at = i;
        end
        checks++; if (rise_at !== CLK_DIV) $display("FAIL async_next_start: got cycle %0d want %0d", rise_at, CLK_DIV); else passes++;
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_window();
        test_levels();
        test_enable_drop();
        test_overrun();
        test_random_windows();
        test_reset_async();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
